// File: rtl/a2e_push_arbiter.sv
// Round-robin, burst-locked arbiter that multiplexes NUM_SRC producer push ports onto the
// single push side of the A2E queue. A granted source keeps the queue for BURST_LEN accepted words.
module a2e_push_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BITWIDTH  = 32,
  parameter int BURST_LEN = 64,
  parameter int CNT_W     = 8,
  parameter int SRC_W     = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_SRC-1:0]           src_push_req,
  input  logic [NUM_SRC*BITWIDTH-1:0]  src_push_data,
  output logic [NUM_SRC-1:0]           src_full,
  output logic                         q_push_req,
  output logic [BITWIDTH-1:0]          q_push_data,
  input  logic                         q_full,
  output logic [NUM_SRC-1:0]           grant,
  output logic [SRC_W-1:0]             grant_id,
  output logic                         burst_done,
  output logic                         dbg_state
);

  // Handshake: a word moves from the owner to the queue in every cycle where
  // q_push_req=1 and q_full=0; src_full mirrors q_full for the owner only.
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_valid;
  logic [SRC_W-1:0]   pick_id;
  logic [SRC_W-1:0]   cand;
  logic [NUM_SRC-1:0] pick_onehot;
  logic               accept;
  logic               last_word;
  int                 scan_idx;

  // Walk downward in offset so the last hit written is the nearest one at/after rr_ptr.
  always_comb begin
    pick_valid  = 1'b0;
    pick_id     = '0;
    cand        = '0;
    scan_idx    = 0;
    pick_onehot = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      scan_idx = (int'(rr_ptr) + j) % NUM_SRC;
      cand     = SRC_W'(scan_idx);
      if (src_push_req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
    pick_onehot[pick_id] = 1'b1;
  end

  always_comb begin
    q_push_req  = 1'b0;
    q_push_data = '0;
    src_full    = '1;
    if (state == BURST) begin
      q_push_req         = src_push_req[grant_id];
      q_push_data        = src_push_data[int'(grant_id) * BITWIDTH +: BITWIDTH];
      src_full[grant_id] = q_full;
    end
  end

  assign accept    = q_push_req && !q_full;
  assign last_word = (cnt == CNT_W'(BURST_LEN - 1));
  assign dbg_state = (state == BURST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BURST;
            grant    <= pick_onehot;
            grant_id <= pick_id;
            cnt      <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            if (last_word) begin
              state      <= IDLE;
              grant      <= '0;
              grant_id   <= '0;
              cnt        <= '0;
              burst_done <= 1'b1;
              // Pointer moves only here, so a waiting source is at most NUM_SRC-1 bursts away.
              rr_ptr     <= (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2e_push_arbiter.sv
// Bench for a2e_push_arbiter: two instances (BURST_LEN=4 and BURST_LEN=1) share stimulus; a
// cycle model of the arbitration rules plus a data scoreboard checks the observed instance.
module tb_a2e_push_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int VW = 13 + W;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           q_full;
  logic           sel;

  logic [N-1:0] f4, f1, g4, g1;
  logic         r4, r1, bd4, bd1, st4, st1;
  logic [W-1:0] d4, d1;
  logic [1:0]   id4, id1;

  always #5 CLK = ~CLK;

  a2e_push_arbiter #(.NUM_SRC(N), .BITWIDTH(W), .BURST_LEN(4), .CNT_W(8), .SRC_W(2)) dut4 (
    .CLK(CLK), .RST(RST), .src_push_req(req), .src_push_data(data), .src_full(f4),
    .q_push_req(r4), .q_push_data(d4), .q_full(q_full), .grant(g4), .grant_id(id4),
    .burst_done(bd4), .dbg_state(st4));

  a2e_push_arbiter #(.NUM_SRC(N), .BITWIDTH(W), .BURST_LEN(1), .CNT_W(8), .SRC_W(2)) dut1 (
    .CLK(CLK), .RST(RST), .src_push_req(req), .src_push_data(data), .src_full(f1),
    .q_push_req(r1), .q_push_data(d1), .q_full(q_full), .grant(g1), .grant_id(id1),
    .burst_done(bd1), .dbg_state(st1));

  logic [N-1:0]  o_full, o_grant;
  logic          o_req, o_done, o_st;
  logic [W-1:0]  o_data;
  logic [1:0]    o_id;
  logic [VW-1:0] obs_vec, exp_vec, exp_mask;

  assign o_full  = sel ? f1  : f4;
  assign o_grant = sel ? g1  : g4;
  assign o_req   = sel ? r1  : r4;
  assign o_done  = sel ? bd1 : bd4;
  assign o_st    = sel ? st1 : st4;
  assign o_data  = sel ? d1  : d4;
  assign o_id    = sel ? id1 : id4;
  assign obs_vec = {o_grant, o_id, o_req, o_full, o_done, o_st, o_data};

  int checks   = 0;
  int failures = 0;

  // Reference model: owner (-1 = nobody), words taken in this burst, rotation start.
  int   m_owner, m_cnt, m_ptr, m_bl, m_done_cnt;
  logic m_done, m_acc;
  int   prod_seq[N];
  int   msq[N];
  logic [W-1:0] exp_q[$];

  task automatic drive_data();
    for (int i = 0; i < N; i++) data[i*W +: W] = 32'(i * 256 + prod_seq[i]);
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_done = 1'b0; m_acc = 1'b0; m_done_cnt = 0;
    exp_q.delete();
  endtask

  // Expected outputs for the current cycle given the model state and current inputs.
  task automatic model_eval();
    logic [N-1:0] eg, ef;
    logic [1:0]   eid;
    logic         er;
    logic [W-1:0] ed;
    eg = '0; ef = '1; eid = 2'd0; er = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eid         = 2'(m_owner);
      er          = req[m_owner];
      ef[m_owner] = q_full;
      ed          = data[m_owner*W +: W];
    end
    exp_vec  = {eg, eid, er, ef, m_done, (m_owner >= 0), ed};
    exp_mask = {{13{1'b1}}, (m_owner < 0 || er) ? {W{1'b1}} : {W{1'b0}}};
    exp_vec  = exp_vec & exp_mask;
    m_acc    = er && !q_full;
    if (m_acc) begin
      exp_q.push_back(32'(m_owner * 256 + msq[m_owner]));
      msq[m_owner]++;
    end
  endtask

  task automatic model_advance();
    bit found;
    m_done = 1'b0;
    found  = 1'b0;
    if (m_owner < 0) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[(m_ptr + j) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + j) % N;
          m_cnt   = 0;
        end
      end
    end else if (m_acc) begin
      m_cnt++;
      if (m_cnt == m_bl) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
        m_done  = 1'b1;
        m_done_cnt++;
      end
    end
  endtask

  task automatic end_cycle();
    for (int i = 0; i < N; i++) if (req[i] && !o_full[i]) prod_seq[i]++;
    model_advance();
    @(posedge CLK);
    #1;
    drive_data();
  endtask

  task automatic apply_reset();
    RST = 1'b1; req = '0; q_full = 1'b0;
    for (int i = 0; i < N; i++) begin prod_seq[i] = 0; msq[i] = 0; end
    drive_data();
    model_reset();
    m_bl = sel ? 1 : 4;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    sel = 1'b0; RST = 1'b1; req = '1; q_full = 1'b0;
    drive_data();
    #2;
    checks++;
    if (obs_vec[VW-1:W] !== 13'b0000_00_0_1111_0_0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", obs_vec[VW-1:W], 13'b0000_00_0_1111_0_0);
    end
    checks++;
    if (o_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_data); end
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      req = '0;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL reset_idle_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL reset_idle_data got=%h exp=%h", o_data, e); end end
      end
      end_cycle();
    end
  endtask

  task automatic test_single_src();
    logic [W-1:0] e;
    int dones;
    sel = 1'b0; apply_reset(); dones = 0;
    for (int c = 0; c < 12; c++) begin
      req = 4'b0100;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL single cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL single_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", o_data, e); end end
      end
      if (o_done) dones++;
      end_cycle();
    end
    checks++;
    if (dones != 2) begin failures++; $display("FAIL single_done_count got=%0d exp=2", dones); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_all_src();
    logic [W-1:0] e;
    logic [N-1:0] prev_g;
    int dones;
    int starts[$];
    sel = 1'b0; apply_reset(); dones = 0; prev_g = '0;
    for (int c = 0; c < 26; c++) begin
      req = 4'b1111;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL all_src cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL all_src_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL all_src_data got=%h exp=%h", o_data, e); end end
      end
      if (o_done) dones++;
      if (o_grant != '0 && prev_g == '0) starts.push_back(int'(o_id));
      prev_g = o_grant;
      end_cycle();
    end
    checks++;
    if (dones != 5) begin failures++; $display("FAIL all_src_done_count got=%0d exp=5", dones); end
    checks++;
    if (starts.size() != 5) begin failures++; $display("FAIL all_src_bursts got=%0d exp=5", starts.size()); end
    for (int k = 0; k < starts.size(); k++) begin
      checks++;
      if (starts[k] != k % 4) begin failures++; $display("FAIL all_src_order idx=%0d got=%0d exp=%0d", k, starts[k], k % 4); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    int stall_left, acc;
    sel = 1'b0; apply_reset(); stall_left = 3; acc = 0;
    for (int c = 0; c < 9; c++) begin
      req    = 4'b0010;
      q_full = (m_owner == 1 && m_cnt == 2 && stall_left > 0) ? 1'b1 : 1'b0;
      if (q_full) stall_left--;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (q_full) begin
        checks++;
        if (o_req !== 1'b1 || o_full[1] !== 1'b1) begin
          failures++; $display("FAIL stall_hold cyc=%0d req=%b full1=%b exp=1,1", c, o_req, o_full[1]);
        end
      end
      if (o_req && !q_full) begin
        acc++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL stall_data got=%h exp=%h", o_data, e); end end
      end
      end_cycle();
    end
    q_full = 1'b0;
    checks++;
    if (acc != 4) begin failures++; $display("FAIL stall_words got=%0d exp=4", acc); end
  endtask

  task automatic test_owner_drop();
    logic [W-1:0] e;
    int drop_left;
    sel = 1'b0; apply_reset(); drop_left = 5;
    for (int c = 0; c < 13; c++) begin
      req    = '0;
      req[0] = (c >= 1);
      req[3] = 1'b1;
      if (m_owner == 3 && m_cnt == 2 && drop_left > 0) begin req[3] = 1'b0; drop_left--; end
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL drop cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (c >= 1 && c <= 9) begin
        checks++;
        if (o_grant !== 4'b1000 || o_full[0] !== 1'b1) begin
          failures++; $display("FAIL drop_lock cyc=%0d grant=%b full0=%b exp=1000,1", c, o_grant, o_full[0]);
        end
      end
      if (c == 11) begin
        checks++;
        if (o_grant !== 4'b0001) begin failures++; $display("FAIL drop_next got=%b exp=0001", o_grant); end
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL drop_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL drop_data got=%h exp=%h", o_data, e); end end
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    sel = 1'b0; apply_reset();
    for (int c = 0; c < 8; c++) begin
      req = (c < 5) ? 4'b0100 : 4'b1000;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rstmid_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", o_data, e); end end
      end
      end_cycle();
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (o_grant !== 4'b0000 || o_req !== 1'b0 || o_full !== 4'b1111) begin
      failures++; $display("FAIL rstmid_async grant=%b req=%b full=%b exp=0000,0,1111", o_grant, o_req, o_full);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      req = 4'b1010;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (c == 1) begin
        checks++;
        if (o_grant !== 4'b0010) begin failures++; $display("FAIL rstmid_winner got=%b exp=0010", o_grant); end
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rstmid_post_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL rstmid_post_data got=%h exp=%h", o_data, e); end end
      end
      end_cycle();
    end
  endtask

  task automatic test_burst_len1();
    logic [W-1:0] e;
    logic [N-1:0] prev_g;
    int acc, dones;
    int starts[$];
    sel = 1'b1; apply_reset(); acc = 0; dones = 0; prev_g = '0;
    for (int c = 0; c < 12; c++) begin
      req = 4'b0011;
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL bl1 cyc=%0d got=%h exp=%h", c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        acc++;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bl1_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL bl1_data got=%h exp=%h", o_data, e); end end
      end
      if (o_done) dones++;
      if (o_grant != '0 && prev_g == '0) starts.push_back(int'(o_id));
      prev_g = o_grant;
      end_cycle();
    end
    checks++;
    if (acc != 6) begin failures++; $display("FAIL bl1_words got=%0d exp=6", acc); end
    checks++;
    if (dones != 5) begin failures++; $display("FAIL bl1_done_count got=%0d exp=5", dones); end
    checks++;
    if (starts.size() != 6) begin failures++; $display("FAIL bl1_bursts got=%0d exp=6", starts.size()); end
    for (int k = 0; k < starts.size(); k++) begin
      checks++;
      if (starts[k] != k % 2) begin failures++; $display("FAIL bl1_order idx=%0d got=%0d exp=%0d", k, starts[k], k % 2); end
    end
  endtask

  task automatic test_random(input logic use_bl1, input int ncyc);
    logic [W-1:0] e;
    int dones;
    sel = use_bl1; apply_reset(); dones = 0;
    for (int c = 0; c < ncyc; c++) begin
      req    = 4'($urandom_range(0, 15));
      q_full = ($urandom_range(0, 3) == 0);
      @(negedge CLK); model_eval();
      checks++;
      if ((obs_vec & exp_mask) !== exp_vec) begin
        failures++; $display("FAIL random bl1=%0b cyc=%0d got=%h exp=%h", use_bl1, c, obs_vec & exp_mask, exp_vec);
      end
      if (o_req && !q_full) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL random_data got=%h exp=none", o_data); end
        else begin e = exp_q.pop_front(); if (o_data !== e) begin failures++; $display("FAIL random_data got=%h exp=%h", o_data, e); end end
      end
      if (o_done) dones++;
      end_cycle();
    end
    q_full = 1'b0;
    checks++;
    if (dones != m_done_cnt) begin failures++; $display("FAIL random_done_count got=%0d exp=%0d", dones, m_done_cnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL random_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    RST = 1'b1; sel = 1'b0; req = '0; q_full = 1'b0;
    for (int i = 0; i < N; i++) begin prod_seq[i] = 0; msq[i] = 0; end
    drive_data();
    model_reset();
    m_bl = 4;
    test_reset();
    test_single_src();
    test_all_src();
    test_stall();
    test_owner_drop();
    test_reset_mid();
    test_burst_len1();
    test_random(1'b0, 300);
    test_random(1'b1, 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a2e_push_arbiter.md
Name: a2e_push_arbiter

Overview:
- Round-robin arbiter that shares the single push side of the A2E queue (32-bit, depth 3) between NUM_SRC producers.
- Grants are burst-locked: a granted source owns the queue for BURST_LEN accepted words, one JPEG 8x8 block by default, then ownership rotates.
- Sits between the producer push interfaces and the queue's PushReq/PushData/Full pins.
- Each producer sees a standard PushReq/Data/Full interface, so it is unaware of sharing.

Parameters:
- NUM_SRC, 4: number of producers, 2..8.
- BITWIDTH, 32: data width; must match the queue.
- BURST_LEN, 64: words per grant, 1..256.
- CNT_W, 8: word-counter width; must satisfy 2^CNT_W >= BURST_LEN.
- SRC_W, 2: source-index width, ceil(log2(NUM_SRC)).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- src_push_req  in  NUM_SRC  per-source push request.
- src_push_data  in  NUM_SRC*BITWIDTH  per-source data; source i occupies bits [i*BITWIDTH +: BITWIDTH].
- src_full  out  NUM_SRC  per-source back-pressure; 1 = push not accepted this cycle.
- q_push_req  out  1  to queue PushReq.
- q_push_data  out  BITWIDTH  to queue PushData.
- q_full  in  1  from queue Full.
- grant  out  NUM_SRC  one-hot current owner; all zero when idle.
- grant_id  out  SRC_W  index of current owner; 0 when idle.
- burst_done  out  1  one-cycle pulse in the cycle after the last word of a burst is accepted.

Behaviour:
- Reset (async, RST=1): state=IDLE, grant=0, grant_id=0, rr_ptr=0, cnt=0, burst_done=0. Outputs while in reset: q_push_req=0, src_full=all ones.
- States: IDLE and BURST.
- IDLE:
  - Scan src_push_req starting at rr_ptr, increasing index, wrapping modulo NUM_SRC.
  - First asserted index k is registered: state<=BURST, grant<=onehot(k), grant_id<=k, cnt<=0.
  - No request: stay in IDLE.
  - Arbitration costs exactly one cycle. No word is accepted in IDLE.
- BURST, combinational path for owner g:
  - q_push_req = src_push_req[g]; q_push_data = data slice g.
  - src_full[g] = q_full; src_full[i != g] = 1.
- Accepted word: q_push_req && !q_full. On each accepted word, cnt<=cnt+1.
- Burst end: when an accepted word occurs with cnt==BURST_LEN-1, on that edge:
  - state<=IDLE, grant<=0, grant_id<=0, cnt<=0;
  - rr_ptr<=(g+1) mod NUM_SRC;
  - burst_done<=1 for one cycle.
- Owner stalls (req low or q_full high): the burst holds indefinitely. No timeout, no preemption.
- Queue side: q_push_req is never asserted in IDLE. The data mux output is don't-care when q_push_req=0, but is driven as zero in IDLE.
- The arbiter never drops or duplicates a word. The word order of one source is preserved; bursts from different sources never interleave.
- Fairness: rr_ptr advances only at burst end. Any requesting source waits at most (NUM_SRC-1) bursts.
- Simultaneous requests at arbitration: lowest index at or after rr_ptr wins.
- BURST_LEN=1: every accepted word ends the burst, so throughput is one word per 2 cycles.
- Reset mid-burst: immediate return to the reset state. The partial burst is abandoned, and the queue contents are the producer's concern.
- cnt never exceeds BURST_LEN-1. No wrap-around is possible.

Test Plan:
1. Reset, then only src 2 requests continuously with data 0x200+n, BURST_LEN=4, q_full=0.
   -> grant=0100 one cycle after request; q_push_req high for 4 consecutive cycles carrying 0x200..0x203; burst_done pulses once; IDLE for 1 cycle; new grant to src 2.
2. All 4 sources request continuously, BURST_LEN=4.
   -> grant order 0,1,2,3,0; each burst is exactly 4 words; no source data appears inside another's burst; burst_done count = 5.
3. src 1 owns the burst; q_full asserted for 3 cycles after word 2.
   -> q_push_req stays high, cnt holds at 2, src_full[1]=1 during the stall; the burst completes with words 3..4 after q_full drops; total still 4.
4. src 3 owns the burst and drops req for 5 cycles mid-burst while src 0 requests.
   -> grant stays 1000; src_full[0]=1 throughout; src 0 is granted only after src 3 completes.
5. RST asserted asynchronously mid-burst after 2 words.
   -> grant=0, q_push_req=0, src_full=1111 immediately. After release, rr_ptr=0, and with src 1 and src 3 requesting, src 1 wins.
6. BURST_LEN=1, srcs 0 and 1 both requesting.
   -> alternating grants 0,1,0,1; accepted words on every other cycle; burst_done after each word.
